// File: rtl/johnson_pkg.sv
// johnson_pkg: shared Johnson-code state type and legality/decode helpers
package johnson_pkg;
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  function automatic logic johnson_legal(logic [31:0] code, int unsigned width);
    logic [31:0] mask, c;
    mask = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
    c = code[width-1] ? ~code & mask : code & mask;
    return (c & (c + 32'd1)) == '0;
  endfunction
  function automatic int unsigned johnson_index(logic [31:0] code, int unsigned width);
    int unsigned pop;
    pop = 0;
    for (int i = 0; i < 32; i++) if (i < width) pop += 32'(code[i]);
    return code[width-1] ? 2 * width - pop : pop;
  endfunction
endpackage

// File: rtl/johnson_code_check.sv
// johnson_code_check: combinational legality check and binary decode of a Johnson word
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    idx
);
  assign legal = johnson_legal(32'(code), WIDTH);
  assign idx = IW'(johnson_index(32'(code), WIDTH));
endmodule

// File: rtl/johnson_decoder.sv
// johnson_decoder: checks and decodes Johnson code samples, tracks lock and counts errors
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOCK_CNT = 2,
  localparam int IW = $clog2(2 * WIDTH),
  localparam int RW = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [7:0]       err_count
);
  state_t state;
  logic [RW-1:0] run;
  logic legal, succ, serr;
  logic [IW-1:0] idx, nxt;
  johnson_code_check #(.WIDTH(WIDTH)) u_check (.code(code), .legal(legal), .idx(idx));
  // the stored index is simply the last legal decode, so index doubles as the predecessor
  assign nxt = (index == IW'(2 * WIDTH - 1)) ? '0 : index + 1'b1;
  assign succ = legal && idx == nxt;
  assign serr = legal && state == LOCKED && !succ;
  assign locked = state == LOCKED;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= UNLOCKED;
      run <= '0;
      index <= '0;
      index_valid <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      err_count <= '0;
    end else begin
      index_valid <= in_valid && legal;
      illegal <= in_valid && !legal;
      seq_err <= in_valid && serr;
      if (in_valid) begin
        if (legal) index <= idx;
        if ((!legal || serr) && err_count != 8'hff) err_count <= err_count + 8'd1;
        if (!legal) state <= UNLOCKED;
        else if (state == UNLOCKED || !succ) begin
          state <= ACQUIRE;
          run <= '0;
        end else if (state == ACQUIRE) begin
          run <= run + 1'b1;
          if (run + 1'b1 == RW'(LOCK_CNT)) state <= LOCKED;
        end
      end
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed vectors checked every cycle against a table-driven reference model
module tb_johnson_decoder;
  localparam int W = 4;
  localparam int LC = 2;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [W-1:0] code = '0;
  logic [2:0] index;
  logic index_valid, illegal, seq_err, locked;
  logic [7:0] err_count;
  int vectors = 0, fails = 0;
  bit started = 0;
  int m_state = 0, m_run = 0, m_index = 0, m_err = 0;
  bit m_iv = 0, m_ill = 0, m_se = 0;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code(code), .index(index),
    .index_valid(index_valid), .illegal(illegal), .seq_err(seq_err), .locked(locked),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // reference sequence built by listing the 2*W code words in order
  function automatic int model_index(logic [W-1:0] c);
    logic [W-1:0] t;
    for (int k = 0; k < 2 * W; k++) begin
      t = (k < W) ? W'((1 << k) - 1) : ~W'((1 << (k - W)) - 1);
      if (t == c) return k;
    end
    return -1;
  endfunction

  initial forever begin
    int k;
    bit s;
    @(posedge clk);
    if (!reset) begin
      m_state = 0; m_run = 0; m_index = 0; m_err = 0; m_iv = 0; m_ill = 0; m_se = 0;
    end else begin
      m_iv = 0; m_ill = 0; m_se = 0;
      if (in_valid) begin
        k = model_index(code);
        if (k < 0) begin
          m_ill = 1;
          m_state = 0;
          m_err = (m_err < 255) ? m_err + 1 : 255;
        end else begin
          s = (k == (m_index + 1) % (2 * W));
          if (m_state == 2 && !s) begin
            m_se = 1;
            m_err = (m_err < 255) ? m_err + 1 : 255;
          end
          if (m_state == 0 || !s) begin
            m_state = 1; m_run = 0;
          end else if (m_state == 1) begin
            m_run++;
            if (m_run == LC) m_state = 2;
          end
          m_index = k;
          m_iv = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      vectors++;
      if (int'(index) != m_index || index_valid !== m_iv || illegal !== m_ill ||
          seq_err !== m_se || locked !== (m_state == 2) || int'(err_count) != m_err) begin
        fails++;
        $display("FAIL cycle@%0t: dut idx=%0d iv=%b ill=%b se=%b lk=%b err=%0d, model idx=%0d iv=%b ill=%b se=%b lk=%b err=%0d",
                 $time, index, index_valid, illegal, seq_err, locked, err_count,
                 m_index, m_iv, m_ill, m_se, m_state == 2, m_err);
      end
    end
  end

  task automatic apply(input logic r, input logic v, input logic [W-1:0] c);
    @(negedge clk);
    reset = r; in_valid = v; code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input int got, input int exp, input int mdl);
    vectors += 2;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: dut=%0d expected=%0d", name, got, exp);
    end
    if (mdl != exp) begin
      fails++;
      $display("FAIL %s_model: model=%0d expected=%0d", name, mdl, exp);
    end
  endtask

  initial begin
    apply(0, 0, '0);
    started = 1;
    apply(0, 0, '0);
    pin("rst_index", index, 0, m_index);
    pin("rst_locked", locked, 0, m_state == 2);
    pin("rst_err", err_count, 0, m_err);
    apply(1, 1, 4'b0000);
    pin("lock_iv0", index_valid, 1, m_iv);
    apply(1, 1, 4'b0001);
    pin("lock_idx1", index, 1, m_index);
    apply(1, 1, 4'b0011);
    pin("lock_after3", locked, 1, m_state == 2);
    apply(1, 1, 4'b0111);
    pin("lock_idx3", index, 3, m_index);
    pin("lock_err0", err_count, 0, m_err);
    apply(1, 1, 4'b1111);
    pin("dec_1111", index, 4, m_index);
    apply(1, 1, 4'b1110);
    pin("dec_1110", index, 5, m_index);
    apply(1, 1, 4'b1100);
    apply(1, 1, 4'b1000);
    pin("dec_1000", index, 7, m_index);
    apply(1, 1, 4'b0000);
    pin("wrap_idx0", index, 0, m_index);
    pin("wrap_locked", locked, 1, m_state == 2);
    pin("wrap_no_seqerr", seq_err, 0, m_se);
    apply(1, 1, 4'b0101);
    pin("ill_pulse", illegal, 1, m_ill);
    pin("ill_hold_idx", index, 0, m_index);
    pin("ill_unlock", locked, 0, m_state == 2);
    pin("ill_err1", err_count, 1, m_err);
    apply(1, 1, 4'b0011);
    pin("reacq_idx2", index, 2, m_index);
    apply(1, 1, 4'b0111);
    apply(1, 1, 4'b1111);
    pin("relock", locked, 1, m_state == 2);
    apply(1, 1, 4'b1000);
    pin("skip_seqerr", seq_err, 1, m_se);
    pin("skip_idx7", index, 7, m_index);
    pin("skip_unlock", locked, 0, m_state == 2);
    pin("skip_err2", err_count, 2, m_err);
    apply(1, 1, 4'b0000);
    apply(1, 1, 4'b0001);
    pin("skip_relock", locked, 1, m_state == 2);
    for (int i = 0; i < 5; i++) apply(1, 0, 4'b0101);
    pin("idle_idx", index, 1, m_index);
    pin("idle_iv", index_valid, 0, m_iv);
    pin("idle_locked", locked, 1, m_state == 2);
    apply(1, 1, 4'b0001);
    pin("repeat_seqerr", seq_err, 1, m_se);
    pin("repeat_err3", err_count, 3, m_err);
    apply(1, 1, 4'b1100);
    pin("acq_jump_no_seqerr", seq_err, 0, m_se);
    pin("acq_jump_idx6", index, 6, m_index);
    for (int i = 0; i < 300; i++) apply(1, 1, (i % 2) ? 4'b1010 : 4'b0100);
    pin("sat_err255", err_count, 255, m_err);
    pin("sat_illegal", illegal, 1, m_ill);
    apply(0, 1, 4'b0001);
    pin("rst2_idx", index, 0, m_index);
    pin("rst2_iv", index_valid, 0, m_iv);
    pin("rst2_err", err_count, 0, m_err);
    pin("rst2_ill", illegal, 0, m_ill);
    apply(1, 1, 4'b0011);
    pin("first_after_rst_idx", index, 2, m_index);
    pin("first_after_rst_se", seq_err, 0, m_se);
    apply(1, 0, 4'b0000);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to `johnson_counter`. Samples a WIDTH-bit Johnson (twisted-ring) code word each valid cycle, checks that it is a legal pattern, and decodes it to a binary state index. It also tracks sequence continuity with a lock state machine and counts errors. It sits on the far end of any path carrying a Johnson-coded count (clock-domain-safe status, one-hot-free sequencers) and gives downstream logic a checked binary count.

## Interface
- `WIDTH`, 4: code width; the sequence has 2·WIDTH states (WIDTH ≥ 2).
- `LOCK_CNT`, 2: consecutive correct successors required to go from ACQUIRE to LOCKED (≥ 1).
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `in_valid` input 1: `code` is sampled on this edge.
- `code` input WIDTH: Johnson code word. The sequence from index 0 is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 (for WIDTH=4).
- `index` output $clog2(2·WIDTH): decoded index of the last legal sample.
- `index_valid` output 1: one-cycle pulse; `index` was updated from a legal sample.
- `illegal` output 1: one-cycle pulse; the sample was not a legal Johnson pattern.
- `seq_err` output 1: one-cycle pulse; the sample was legal but not the successor while LOCKED.
- `locked` output 1: high in the LOCKED state.
- `err_count` output 8: saturating count of `illegal` plus `seq_err` events.

## Operation
- **Legality:**
  - If msb = 0, `code` must be a run of ones from the LSB: (code & (code+1)) == 0.
  - If msb = 1, ~code must satisfy the same test.
- **Decode:** with pop = popcount(code), index = pop if msb = 0, otherwise 2·WIDTH − pop. Examples: 1111→4, 1110→5, 1000→7.
- **Successor:** expected = (stored index + 1) mod 2·WIDTH. The wrap from 2·WIDTH−1 to 0 is a legal successor.
- **FSM states:** UNLOCKED, ACQUIRE, LOCKED.
  - UNLOCKED:
    - legal → store index, run := 0, go to ACQUIRE.
    - illegal → stay in UNLOCKED.
  - ACQUIRE:
    - successor → run++. When run reaches LOCK_CNT, go to LOCKED.
    - legal non-successor → store index, run := 0, stay. No `seq_err`.
    - illegal → UNLOCKED.
  - LOCKED:
    - successor → stay.
    - legal non-successor → `seq_err` pulse, store index, run := 0, go to ACQUIRE.
    - illegal → UNLOCKED.
- **Repeated code:** a code equal to the previous one is a non-successor.
- **Every legal sample:** updates `index` and pulses `index_valid`, in every state.
- **Every illegal sample:** pulses `illegal`. `index` holds its last value.
- **Error precedence:** `illegal` and `seq_err` are mutually exclusive; illegal wins. `err_count` increments by 1 per event and saturates at 255.
- **`in_valid` low:** no state, index, or count change. All pulses are 0.

## Timing
- All outputs are registered. A response appears the cycle after the `in_valid` edge, so latency is 1.
- **Reset:** while `reset` = 0 at an edge, the FSM goes to UNLOCKED, run = 0, `index` = 0, and `index_valid`, `illegal`, `seq_err`, `locked`, `err_count` are all 0.
- **Reset mid-operation:** reset overrides any sample on the same edge. The next valid sample is treated as the first (no predecessor, no `seq_err`).
- `locked` rises in the cycle after the LOCK_CNT-th consecutive successor. It falls in the cycle after the first illegal sample or `seq_err`.
- Back-to-back `in_valid` every cycle is supported with no stall.

## Structure
- **Shared package `johnson_pkg`:**
  - state enum (UNLOCKED, ACQUIRE, LOCKED);
  - function `johnson_legal(code)`;
  - function `johnson_index(code)`.
  
  `johnson_counter` benches reuse these functions for checking.
- **Sub-module `johnson_code_check`:** combinational; legality and index decode. It is instantiated once.
- **Top level:** holds the FSM, the stored index, the run counter, and the saturating error counter.

## Test plan
- **Clean lock:** reset low for 2 cycles. Feed 0000, 0001, 0011, 0111 on consecutive cycles. Expect `index` = 0, 1, 2, 3 with `index_valid` each cycle. `locked` = 1 after the 3rd sample (LOCK_CNT = 2). `err_count` = 0.
- **Wrap-around:** once locked, feed 1100, 1000, 0000. Expect `index` = 6, 7, 0, `locked` stays 1, no `seq_err`.
- **Illegal code:** while locked, feed 0101. Expect `illegal` pulse, `index` holds, `locked` → 0, `err_count` = 1. Then feed 0011 → ACQUIRE, `index` = 2.
- **Sequence skip:** while locked at index 2, feed 1111. Expect `seq_err` pulse, `index` = 4, `locked` → 0, `err_count` +1. Then feed 1110, 1100 → `locked` back to 1.
- **Idle and stall:** with `in_valid` = 0 for 5 cycles, nothing changes. Then repeat the same code twice → `seq_err` on the second (if locked).
- **Saturation and reset:** feed 300 illegal codes → `err_count` = 255. Assert `reset` with `in_valid` high and code 0001 → all outputs 0 the next cycle.
